// File: rtl/ps2_text_writer_pkg.sv
// ps2_text_writer_pkg: scan-code constants, FSM states and screen geometry defaults
package ps2_text_writer_pkg;
    localparam int DEF_COLS = 128;
    localparam int DEF_ROWS = 48;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    typedef enum logic [2:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK, ST_WRITE} state_t;
endpackage

// File: rtl/ps2_text_writer_if.sv
// ps2_text_writer_if: scan-code input and text-RAM port-A / cursor outputs
interface ps2_text_writer_if #(
    parameter int ADDR_W = 13,
    parameter int CHAR_W = 7
);
    logic              scan_ready;
    logic [7:0]        scan_code;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [CHAR_W-1:0] din;
    logic [ADDR_W-1:0] cursor_addr;
    logic              shift_on;
    modport master (output scan_ready, scan_code, input we, addr, din, cursor_addr, shift_on);
    modport slave  (input scan_ready, scan_code, output we, addr, din, cursor_addr, shift_on);
endinterface

// File: rtl/ps2_scan_decode.sv
// ps2_scan_decode: set-2 make code to 7-bit ASCII; entry = {is_letter, unshifted, shifted}
module ps2_scan_decode
    import ps2_text_writer_pkg::*;
(
    input  logic [7:0] i_code,
    input  logic       i_shift,
    input  logic       i_caps,
    output logic       o_valid,
    output logic [6:0] o_char
);
    logic [16:0] w_ent;
    logic        w_up;
    always_comb begin
        case (i_code)
            8'h1C: w_ent = {1'b1, "aA"};  8'h32: w_ent = {1'b1, "bB"};  8'h21: w_ent = {1'b1, "cC"};
            8'h23: w_ent = {1'b1, "dD"};  8'h24: w_ent = {1'b1, "eE"};  8'h2B: w_ent = {1'b1, "fF"};
            8'h34: w_ent = {1'b1, "gG"};  8'h33: w_ent = {1'b1, "hH"};  8'h43: w_ent = {1'b1, "iI"};
            8'h3B: w_ent = {1'b1, "jJ"};  8'h42: w_ent = {1'b1, "kK"};  8'h4B: w_ent = {1'b1, "lL"};
            8'h3A: w_ent = {1'b1, "mM"};  8'h31: w_ent = {1'b1, "nN"};  8'h44: w_ent = {1'b1, "oO"};
            8'h4D: w_ent = {1'b1, "pP"};  8'h15: w_ent = {1'b1, "qQ"};  8'h2D: w_ent = {1'b1, "rR"};
            8'h1B: w_ent = {1'b1, "sS"};  8'h2C: w_ent = {1'b1, "tT"};  8'h3C: w_ent = {1'b1, "uU"};
            8'h2A: w_ent = {1'b1, "vV"};  8'h1D: w_ent = {1'b1, "wW"};  8'h22: w_ent = {1'b1, "xX"};
            8'h35: w_ent = {1'b1, "yY"};  8'h1A: w_ent = {1'b1, "zZ"};
            8'h45: w_ent = {1'b0, "0)"};  8'h16: w_ent = {1'b0, "1!"};  8'h1E: w_ent = {1'b0, "2@"};
            8'h26: w_ent = {1'b0, "3#"};  8'h25: w_ent = {1'b0, "4$"};  8'h2E: w_ent = {1'b0, "5%"};
            8'h36: w_ent = {1'b0, "6^"};  8'h3D: w_ent = {1'b0, "7&"};  8'h3E: w_ent = {1'b0, "8*"};
            8'h46: w_ent = {1'b0, "9("};
            8'h0E: w_ent = {1'b0, "`~"};  8'h4E: w_ent = {1'b0, "-_"};  8'h55: w_ent = {1'b0, "=+"};
            8'h54: w_ent = {1'b0, "[{"};  8'h5B: w_ent = {1'b0, "]}"};  8'h5D: w_ent = {1'b0, 8'h5C, 8'h7C};
            8'h4C: w_ent = {1'b0, ";:"};  8'h52: w_ent = {1'b0, 8'h27, 8'h22}; 8'h41: w_ent = {1'b0, ",<"};
            8'h49: w_ent = {1'b0, ".>"};  8'h4A: w_ent = {1'b0, "/?"};
            SC_SPACE: w_ent = {1'b0, "  "};
            default:  w_ent = '0;
        endcase
    end
    assign w_up    = w_ent[16] ? (i_shift ^ i_caps) : i_shift;
    assign o_valid = |w_ent[15:0];
    assign o_char  = w_up ? w_ent[6:0] : w_ent[14:8];
endmodule

// File: rtl/ps2_text_writer.sv
// ps2_text_writer: PS/2 scan codes to text-RAM writes at a wrapping hardware cursor.
// Optional Caps Lock toggle on code 58 when PS2_TEXT_WRITER_CAPS_EN is defined.
module ps2_text_writer
    import ps2_text_writer_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = 13,
    parameter int CHAR_W = 7
) (
    input logic              clk,
    input logic              reset,
    ps2_text_writer_if.slave bus
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    state_t            r_state;
    logic [1:0]        r_sync;
    logic              r_edge, r_vld, r_pend, r_we, r_adv, r_shift;
    logic [7:0]        r_code;
    logic [ADDR_W-1:0] r_addr;
    logic [CHAR_W-1:0] r_din;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic              w_byte, w_valid, w_caps, w_col_last, w_row_last, w_shift_code;
    logic [6:0]        w_char;
    logic [ROW_W-1:0]  w_row_nxt, w_row_up, w_row_dn, w_row_fw, w_row_bk;
    logic [COL_W-1:0]  w_col_fw, w_col_bk;
`ifdef PS2_TEXT_WRITER_CAPS_EN
    logic r_caps;
    assign w_caps = r_caps;
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_caps <= 1'b0;
        else if (r_state == ST_IDLE && w_byte && r_code == SC_CAPS) r_caps <= ~r_caps;
`else
    assign w_caps = 1'b0;
`endif
    ps2_scan_decode u_dec (
        .i_code (r_code),
        .i_shift(r_shift),
        .i_caps (w_caps),
        .o_valid(w_valid),
        .o_char (w_char)
    );
    assign w_byte       = r_vld | r_pend;
    assign w_shift_code = (r_code == SC_LSHIFT) || (r_code == SC_RSHIFT);
    assign w_col_last   = r_col == COL_W'(COLS - 1);
    assign w_row_last   = r_row == ROW_W'(ROWS - 1);
    assign w_row_nxt    = w_row_last ? '0 : r_row + ROW_W'(1);
    assign w_row_up     = (r_row == '0) ? r_row : r_row - ROW_W'(1);
    assign w_row_dn     = w_row_last ? r_row : r_row + ROW_W'(1);
    assign w_col_fw     = w_col_last ? '0 : r_col + COL_W'(1);
    assign w_row_fw     = w_col_last ? w_row_nxt : r_row;
    // stepping back from column 0 of row 0 pins the cursor at the origin
    assign w_col_bk     = (r_col != '0) ? r_col - COL_W'(1) : (r_row == '0) ? '0 : COL_W'(COLS - 1);
    assign w_row_bk     = (r_col != '0) ? r_row : w_row_up;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync  <= '0;
            r_edge  <= 1'b0;
            r_vld   <= 1'b0;
            r_code  <= '0;
            r_pend  <= 1'b0;
            r_we    <= 1'b0;
            r_adv   <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_shift <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_state <= ST_IDLE;
        end else begin
            r_sync <= {r_sync[0], bus.scan_ready};
            r_edge <= r_sync[1];
            r_vld  <= r_sync[1] & ~r_edge;
            if (r_sync[1] & ~r_edge) r_code <= bus.scan_code;
            // a byte landing in WRITE is replayed from r_code in the next IDLE cycle
            r_pend <= (r_state == ST_WRITE) & r_vld;
            r_we   <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_byte) begin
                    if (r_code == SC_BRK) r_state <= ST_BRK;
                    else if (r_code == SC_EXT) r_state <= ST_EXT;
                    else if (w_shift_code) r_shift <= 1'b1;
                    else if (r_code == SC_ENTER) begin
                        r_row <= w_row_nxt;
                        r_col <= '0;
                    end else if (r_code == SC_BKSP) begin
                        r_row   <= w_row_bk;
                        r_col   <= w_col_bk;
                        r_addr  <= {w_row_bk, w_col_bk};
                        r_din   <= CHAR_W'(7'h20);
                        r_we    <= 1'b1;
                        r_adv   <= 1'b0;
                        r_state <= ST_WRITE;
                    end else if (w_valid) begin
                        r_addr  <= {r_row, r_col};
                        r_din   <= CHAR_W'(w_char);
                        r_we    <= 1'b1;
                        r_adv   <= 1'b1;
                        r_state <= ST_WRITE;
                    end
                end
                ST_BRK: if (w_byte) begin
                    if (w_shift_code) r_shift <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_EXT: if (w_byte) begin
                    r_state <= (r_code == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
                    if (r_code == SC_LEFT) begin
                        r_row <= w_row_bk;
                        r_col <= w_col_bk;
                    end
                    if (r_code == SC_RIGHT) begin
                        r_row <= w_row_fw;
                        r_col <= w_col_fw;
                    end
                    if (r_code == SC_UP) r_row <= w_row_up;
                    if (r_code == SC_DOWN) r_row <= w_row_dn;
                end
                ST_EXT_BRK: if (w_byte) r_state <= ST_IDLE;
                ST_WRITE: begin
                    r_state <= ST_IDLE;
                    if (r_adv) begin
                        r_row <= w_row_fw;
                        r_col <= w_col_fw;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    assign bus.we          = r_we;
    assign bus.addr        = r_addr;
    assign bus.din         = r_din;
    assign bus.cursor_addr = {r_row, r_col};
    assign bus.shift_on    = r_shift;
endmodule

// File: tb/tb_ps2_text_writer.sv
// tb_ps2_text_writer: directed and random scan-code streams against a linear-cursor keyboard model
module tb_ps2_text_writer;
    localparam int COLS  = 128;
    localparam int ROWS  = 48;
    localparam int NCELL = COLS * ROWS;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ps2_text_writer_if #(.ADDR_W(13), .CHAR_W(7)) bus ();
    ps2_text_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(13), .CHAR_W(7)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad = 0;
    logic [19:0] wq[$];
    logic [19:0] eq[$];
    logic [7:0] lo_t[logic [7:0]];
    logic [7:0] hi_t[logic [7:0]];
    bit let_t[logic [7:0]];
    int m_pos;
    bit m_shift, m_caps, m_brk, m_ext, m_extbrk;

    always @(negedge clk) if (reset && bus.we === 1'b1) wq.push_back({bus.addr, bus.din});

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic void init_tables();
        string ls, ds, dh;
        logic [7:0] lc[26];
        logic [7:0] dc[10];
        logic [7:0] pc[11];
        logic [7:0] pl[11];
        logic [7:0] pu[11];
        ls = "abcdefghijklmnopqrstuvwxyz";
        lc = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
               8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        ds = "0123456789";
        dh = ")!@#$%^&*(";
        dc = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        pl = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
        pu = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};
        pc = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
        for (int i = 0; i < 26; i++) begin
            lo_t[lc[i]] = ls[i];
            hi_t[lc[i]] = ls[i] - 8'd32;
            let_t[lc[i]] = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            lo_t[dc[i]] = ds[i];
            hi_t[dc[i]] = dh[i];
            let_t[dc[i]] = 1'b0;
        end
        for (int i = 0; i < 11; i++) begin
            lo_t[pc[i]] = pl[i];
            hi_t[pc[i]] = pu[i];
            let_t[pc[i]] = 1'b0;
        end
        lo_t[8'h29] = 8'h20;
        hi_t[8'h29] = 8'h20;
        let_t[8'h29] = 1'b0;
    endfunction

    function automatic logic [12:0] addr_of(input int p);
        return 13'((p / COLS) * 128 + p % COLS);
    endfunction

    function automatic void model_reset();
        m_pos = 0;
        {m_shift, m_caps, m_brk, m_ext, m_extbrk} = '0;
    endfunction

    function automatic void model_key(input logic [7:0] b);
        logic [7:0] ch;
        bit up;
        if (m_brk) begin
            m_brk = 1'b0;
            if (b == 8'h12 || b == 8'h59) m_shift = 1'b0;
            return;
        end
        if (m_extbrk) begin
            m_extbrk = 1'b0;
            return;
        end
        if (m_ext) begin
            m_ext = 1'b0;
            if (b == 8'hF0) m_extbrk = 1'b1;
            else if (b == 8'h6B) m_pos = (m_pos == 0) ? 0 : m_pos - 1;
            else if (b == 8'h74) m_pos = (m_pos + 1) % NCELL;
            else if (b == 8'h75) m_pos = (m_pos >= COLS) ? m_pos - COLS : m_pos;
            else if (b == 8'h72) m_pos = (m_pos < NCELL - COLS) ? m_pos + COLS : m_pos;
            return;
        end
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'h12 || b == 8'h59) m_shift = 1'b1;
`ifdef PS2_TEXT_WRITER_CAPS_EN
        else if (b == 8'h58) m_caps = ~m_caps;
`endif
        else if (b == 8'h66) begin
            m_pos = (m_pos == 0) ? 0 : m_pos - 1;
            eq.push_back({addr_of(m_pos), 7'h20});
        end else if (b == 8'h5A) m_pos = ((m_pos / COLS + 1) % ROWS) * COLS;
        else if (lo_t.exists(b)) begin
            up = let_t[b] ? (m_shift ^ m_caps) : m_shift;
            ch = up ? hi_t[b] : lo_t[b];
            eq.push_back({addr_of(m_pos), ch[6:0]});
            m_pos = (m_pos + 1) % NCELL;
        end
    endfunction

    function automatic logic [19:0] last_wr();
        return (wq.size() > 0) ? wq[$] : 20'hFFFFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_nwr"}, wq.size(), eq.size());
        while (wq.size() > 0 && eq.size() > 0) chk({tag, "_wr"}, wq.pop_front(), eq.pop_front());
        wq.delete();
        eq.delete();
        chk({tag, "_cur"}, bus.cursor_addr, addr_of(m_pos));
        chk({tag, "_shift"}, bus.shift_on, m_shift);
    endtask

    task automatic send(input logic [7:0] b);
        model_key(b);
        bus.scan_code = b;
        bus.scan_ready = 1'b1;
        repeat (10) @(negedge clk);
        bus.scan_ready = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_chk(input logic [7:0] b, input string tag);
        send(b);
        chk_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_we", bus.we, 1'b0);
        chk("rst_addr", bus.addr, 13'h0);
        chk("rst_din", bus.din, 7'h0);
        chk("rst_cur", bus.cursor_addr, 13'h0);
        chk("rst_shift", bus.shift_on, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        wq.delete();
        eq.delete();
    endtask

    logic [7:0] pool[18] = '{8'hF0, 8'hE0, 8'h12, 8'h59, 8'h58, 8'h66, 8'h5A, 8'h29, 8'h6B,
                             8'h74, 8'h75, 8'h72, 8'h1C, 8'h32, 8'h16, 8'h45, 8'h4E, 8'h4A};

    initial begin
        bit seen;
        logic [7:0] b;
        init_tables();
        model_reset();
        bus.scan_ready = 1'b0;
        bus.scan_code = 8'h00;
        @(negedge clk);
        do_reset();

        send(8'h1C);
        chk("t1_wr", last_wr(), {13'h0000, 7'h61});
        chk_all("t1_make");
        send_chk(8'hF0, "t1_brk");
        send_chk(8'h1C, "t1_brkcode");
        chk("t1_cur", bus.cursor_addr, 13'h0001);

        do_reset();
        send_chk(8'h12, "t2_shdn");
        chk("t2_shift_on", bus.shift_on, 1'b1);
        send(8'h1C);
        chk("t2_wrA", last_wr(), {13'h0000, 7'h41});
        chk_all("t2_A");
        chk("t2_shift_held", bus.shift_on, 1'b1);
        send_chk(8'hF0, "t2_f0");
        send_chk(8'h12, "t2_shup");
        chk("t2_shift_off", bus.shift_on, 1'b0);
        send(8'h1C);
        chk("t2_wra", last_wr(), {13'h0001, 7'h61});
        chk_all("t2_a");

        do_reset();
        for (int i = 0; i < 127; i++) begin
            send(8'hE0);
            send(8'h74);
        end
        chk_all("t3_right");
        chk("t3_at7f", bus.cursor_addr, 13'h007F);
        send(8'h16);
        chk("t3_wr7f", last_wr(), {13'h007F, 7'h31});
        chk_all("t3_rowwrap");
        chk("t3_cur80", bus.cursor_addr, 13'h0080);
        send(8'hE0);
        send(8'h6B);
        for (int i = 0; i < 47; i++) begin
            send(8'hE0);
            send(8'h72);
        end
        chk_all("t3_down");
        chk("t3_at17ff", bus.cursor_addr, 13'h17FF);
        send(8'h16);
        chk("t3_wr17ff", last_wr(), {13'h17FF, 7'h31});
        chk_all("t3_scrwrap");
        chk("t3_cur0", bus.cursor_addr, 13'h0000);

        do_reset();
        send(8'hE0);
        send(8'h74);
        send(8'hE0);
        send(8'h72);
        chk_all("t4_moves");
        chk("t4_cur81", bus.cursor_addr, 13'h0081);
        send(8'h66);
        chk("t4_bs_wr", last_wr(), {13'h0080, 7'h20});
        chk_all("t4_bs");
        chk("t4_cur80", bus.cursor_addr, 13'h0080);

        model_key(8'h1C);
        bus.scan_code = 8'h1C;
        bus.scan_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("lat_k2_we", bus.we, 1'b0);
        @(negedge clk);
        chk("lat_k3_we", bus.we, 1'b1);
        chk("lat_k3_addr", bus.addr, 13'h0080);
        chk("lat_k3_din", bus.din, 7'h61);
        @(negedge clk);
        chk("lat_k4_we", bus.we, 1'b0);
        repeat (6) @(negedge clk);
        bus.scan_ready = 1'b0;
        repeat (6) @(negedge clk);
        chk_all("lat");

        model_key(8'h1C);
        model_key(8'h32);
        bus.scan_code = 8'h1C;
        bus.scan_ready = 1'b1;
        @(negedge clk);
        bus.scan_ready = 1'b0;
        @(negedge clk);
        bus.scan_ready = 1'b1;
        @(negedge clk);
        bus.scan_code = 8'h32;
        repeat (10) @(negedge clk);
        bus.scan_ready = 1'b0;
        repeat (6) @(negedge clk);
        chk_all("b2b");
        send_chk(8'h5A, "enter");

        for (int i = 0; i < 150; i++) begin
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 17)];
            send_chk(b, "rnd");
        end

        do_reset();
        bus.scan_code = 8'h4D;
        bus.scan_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.we === 1'b1);
        end
        chk("rstw_seen", seen, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk("rstw_we_drop", bus.we, 1'b0);
        chk("rstw_cur", bus.cursor_addr, 13'h0000);
        bus.scan_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        wq.delete();
        eq.delete();
        send(8'h1C);
        chk("rstw_after", last_wr(), {13'h0000, 7'h61});
        chk_all("rstw_resume");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
